// File: rtl/render_pkg.sv
// Shared rendering constants for the sprite pipeline.
//   TRANSPARENT_KEY : colour key treated as see-through
//   SCREEN_W/H      : visible screen size
//   SPR_W/H_DEF     : default sprite dimensions
//   player_state_e  : animation frame index per player state
package render_pkg;

    localparam logic [7:0] TRANSPARENT_KEY = 8'hE3;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int SPR_W_DEF    = 113;
    localparam int SPR_H_DEF    = 157;
    localparam int N_FRAMES_DEF = 11;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        WALK_1 = 4'd1,
        WALK_2 = 4'd2,
        WALK_3 = 4'd3,
        JUMP   = 4'd4,
        CROUCH = 4'd5,
        PUNCH  = 4'd6,
        KICK   = 4'd7,
        HIT    = 4'd8,
        KO     = 4'd9,
        BLOCK  = 4'd10
    } player_state_e;

endpackage

// File: rtl/sprite_addr_gen.sv
// Per-layer hit test and ROM address generation (first pipeline stage).
//   clk, rst            : pixel clock, async active-high reset
//   pixel_x, pixel_y    : current pixel
//   spr_x, spr_y        : layer top-left corner
//   spr_frame           : animation frame index
//   spr_en/flip/flash   : enable, horizontal mirror, flash request
//   flash_phase         : frame-counter bit that blanks flashing layers
//   rom_addr            : registered ROM address (0 when no hit)
//   hit                 : registered hit flag
import render_pkg::*;

module sprite_addr_gen #(
    parameter int SPR_W    = SPR_W_DEF,
    parameter int SPR_H    = SPR_H_DEF,
    parameter int N_FRAMES = N_FRAMES_DEF,
    parameter int ADDR_W   = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic [9:0]        spr_x,
    input  logic [9:0]        spr_y,
    input  logic [3:0]        spr_frame,
    input  logic              spr_en,
    input  logic              spr_flip,
    input  logic              spr_flash,
    input  logic              flash_phase,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              hit
);

    logic [10:0]       x_end;
    logic [10:0]       y_end;
    logic              in_box;
    logic              frame_ok;
    logic              hit_comb;
    logic [9:0]        rel_x;
    logic [9:0]        rel_y;
    logic [31:0]       col;
    logic [ADDR_W-1:0] addr_comb;

    always_comb begin
        // Right/bottom bounds in 11 bits so a sprite near column 1023 does
        // not wrap around and catch pixels at the left of the screen.
        x_end    = {1'b0, spr_x} + 11'(SPR_W);
        y_end    = {1'b0, spr_y} + 11'(SPR_H);
        in_box   = (pixel_x >= spr_x) && (pixel_y >= spr_y) &&
                   ({1'b0, pixel_x} < x_end) && ({1'b0, pixel_y} < y_end);
        frame_ok = 32'(spr_frame) < 32'(N_FRAMES);
        hit_comb = spr_en && frame_ok && in_box && !(spr_flash && flash_phase);

        rel_x     = pixel_x - spr_x;
        rel_y     = pixel_y - spr_y;
        col       = spr_flip ? (32'(SPR_W - 1) - 32'(rel_x)) : 32'(rel_x);
        addr_comb = ADDR_W'(32'(spr_frame) * 32'(SPR_W * SPR_H) +
                            32'(rel_y) * 32'(SPR_W) + col);
    end

    // Stage A boundary: address and hit registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit      <= 1'b0;
            rom_addr <= '0;
        end else begin
            hit      <= hit_comb;
            rom_addr <= hit_comb ? addr_comb : '0;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// N-layer sprite compositor: issues per-layer ROM addresses, waits ROM_LAT
// cycles for ROM data, then picks the highest-priority opaque sprite pixel
// (layer 0 first) over the background.
//   clk, rst          : pixel clock, async active-high reset
//   pix_valid         : pixel_x/pixel_y/bg_pixel valid
//   pixel_x, pixel_y  : current pixel position
//   bg_pixel          : background colour
//   frame_start       : one-cycle pulse per frame, advances the flash counter
//   spr_*             : packed per-layer sprite controls
//   rom_addr          : packed per-layer registered ROM addresses
//   rom_q             : packed per-layer ROM data, ROM_LAT cycles after address
//   pixel_out(_valid) : composited pixel, ROM_LAT+2 cycles after pix_valid
import render_pkg::*;

module sprite_compositor #(
    parameter int         N_SPR       = 2,
    parameter int         SPR_W       = SPR_W_DEF,
    parameter int         SPR_H       = SPR_H_DEF,
    parameter int         N_FRAMES    = N_FRAMES_DEF,
    parameter int         ADDR_W      = 18,
    parameter int         ROM_LAT     = 1,
    parameter logic [7:0] TRANSPARENT = TRANSPARENT_KEY,
    parameter int         FLASH_BIT   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_valid,
    input  logic [9:0]              pixel_x,
    input  logic [9:0]              pixel_y,
    input  logic [7:0]              bg_pixel,
    input  logic                    frame_start,
    input  logic [N_SPR*10-1:0]     spr_x,
    input  logic [N_SPR*10-1:0]     spr_y,
    input  logic [N_SPR*4-1:0]      spr_frame,
    input  logic [N_SPR-1:0]        spr_en,
    input  logic [N_SPR-1:0]        spr_flip,
    input  logic [N_SPR-1:0]        spr_flash,
    output logic [N_SPR*ADDR_W-1:0] rom_addr,
    input  logic [N_SPR*8-1:0]      rom_q,
    output logic [7:0]              pixel_out,
    output logic                    pixel_out_valid
);

    localparam logic [FLASH_BIT:0] FCNT_ONE = 1;

    logic [FLASH_BIT:0] fcnt;
    logic [N_SPR-1:0]   hit_p0;
    logic [7:0]         bg_p0;
    logic               vld_p0;
    logic [N_SPR-1:0]   hit_dly [ROM_LAT];
    logic [7:0]         bg_dly  [ROM_LAT];
    logic               vld_dly [ROM_LAT];
    logic [7:0]         pix_sel;

    // Frame counter; a pixel sampled together with frame_start sees the old count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt <= '0;
        end else if (frame_start) begin
            fcnt <= fcnt + FCNT_ONE;
        end
    end

    for (genvar i = 0; i < N_SPR; i++) begin : g_layer
        sprite_addr_gen #(
            .SPR_W    (SPR_W),
            .SPR_H    (SPR_H),
            .N_FRAMES (N_FRAMES),
            .ADDR_W   (ADDR_W)
        ) u_addr (
            .clk         (clk),
            .rst         (rst),
            .pixel_x     (pixel_x),
            .pixel_y     (pixel_y),
            .spr_x       (spr_x[i*10 +: 10]),
            .spr_y       (spr_y[i*10 +: 10]),
            .spr_frame   (spr_frame[i*4 +: 4]),
            .spr_en      (spr_en[i]),
            .spr_flip    (spr_flip[i]),
            .spr_flash   (spr_flash[i]),
            .flash_phase (fcnt[FLASH_BIT]),
            .rom_addr    (rom_addr[i*ADDR_W +: ADDR_W]),
            .hit         (hit_p0[i])
        );
    end

    // Stage A boundary: background and valid travel with the hit vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bg_p0  <= '0;
            vld_p0 <= 1'b0;
        end else begin
            bg_p0  <= bg_pixel;
            vld_p0 <= pix_valid;
        end
    end

    // Delay boundary: align hit/bg/valid with rom_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ROM_LAT; k++) begin
                hit_dly[k] <= '0;
                bg_dly[k]  <= '0;
                vld_dly[k] <= 1'b0;
            end
        end else begin
            hit_dly[0] <= hit_p0;
            bg_dly[0]  <= bg_p0;
            vld_dly[0] <= vld_p0;
            for (int k = 1; k < ROM_LAT; k++) begin
                hit_dly[k] <= hit_dly[k-1];
                bg_dly[k]  <= bg_dly[k-1];
                vld_dly[k] <= vld_dly[k-1];
            end
        end
    end

    // Walk from lowest priority upwards so layer 0 wins when several are opaque
    always_comb begin
        pix_sel = bg_dly[ROM_LAT-1];
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (hit_dly[ROM_LAT-1][i] && (rom_q[i*8 +: 8] != TRANSPARENT)) begin
                pix_sel = rom_q[i*8 +: 8];
            end
        end
    end

    // Stage C boundary: output holds its last value on invalid cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_out       <= '0;
            pixel_out_valid <= 1'b0;
        end else begin
            pixel_out_valid <= vld_dly[ROM_LAT-1];
            if (vld_dly[ROM_LAT-1]) begin
                pixel_out <= pix_sel;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
module tb_sprite_compositor;

    localparam int SPR_W     = 113;
    localparam int SPR_H     = 157;
    localparam int N_FRAMES  = 11;
    localparam int ADDR_W    = 18;
    localparam int FLASH_BIT = 2;
    localparam logic [7:0] TKEY = 8'hE3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic [7:0]  bg_pixel = '0;
    logic        frame_start = 1'b0;
    logic [9:0]  sx [2];
    logic [9:0]  sy [2];
    logic [3:0]  sf [2];
    logic [1:0]  en = '0;
    logic [1:0]  flip = '0;
    logic [1:0]  flash = '0;
    logic [19:0] spr_x;
    logic [19:0] spr_y;
    logic [7:0]  spr_frame;
    logic [35:0] rom_addr;
    logic [15:0] rom_q = '0;
    logic [7:0]  pixel_out;
    logic        pixel_out_valid;

    assign spr_x     = {sx[1], sx[0]};
    assign spr_y     = {sy[1], sy[0]};
    assign spr_frame = {sf[1], sf[0]};

    sprite_compositor dut (
        .clk             (clk),
        .rst             (rst),
        .pix_valid       (pix_valid),
        .pixel_x         (pixel_x),
        .pixel_y         (pixel_y),
        .bg_pixel        (bg_pixel),
        .frame_start     (frame_start),
        .spr_x           (spr_x),
        .spr_y           (spr_y),
        .spr_frame       (spr_frame),
        .spr_en          (en),
        .spr_flip        (flip),
        .spr_flash       (flash),
        .rom_addr        (rom_addr),
        .rom_q           (rom_q),
        .pixel_out       (pixel_out),
        .pixel_out_valid (pixel_out_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ROM contents: hash of address, with per-address overrides for directed tests
    logic [7:0] ovr0 [int];
    logic [7:0] ovr1 [int];

    function automatic logic [7:0] mem(int l, int a);
        if (l == 0 && ovr0.exists(a)) return ovr0[a];
        if (l == 1 && ovr1.exists(a)) return ovr1[a];
        return 8'(a * 7 + l * 53 + 1);
    endfunction

    // Synchronous one-cycle ROMs
    always @(posedge clk) begin
        rom_q[7:0]  <= mem(0, int'(rom_addr[17:0]));
        rom_q[15:8] <= mem(1, int'(rom_addr[35:18]));
    end

    // ---------------- behavioural model ----------------
    function automatic bit m_hit(int i, int fc);
        int px = int'(pixel_x);
        int py = int'(pixel_y);
        int x0 = int'(sx[i]);
        int y0 = int'(sy[i]);
        if (!en[i]) return 0;
        if (int'(sf[i]) >= N_FRAMES) return 0;
        if (px < x0 || px >= x0 + SPR_W || py < y0 || py >= y0 + SPR_H) return 0;
        if (flash[i] && (((fc >> FLASH_BIT) & 1) == 1)) return 0;
        return 1;
    endfunction

    function automatic int m_addr(int i);
        int rx  = int'(pixel_x) - int'(sx[i]);
        int ry  = int'(pixel_y) - int'(sy[i]);
        int col = flip[i] ? (SPR_W - 1 - rx) : rx;
        return (int'(sf[i]) * SPR_W * SPR_H + ry * SPR_W + col) % (1 << ADDR_W);
    endfunction

    function automatic logic [7:0] m_pix(int fc);
        for (int i = 0; i < 2; i++) begin
            if (m_hit(i, fc) && mem(i, m_addr(i)) != TKEY) return mem(i, m_addr(i));
        end
        return bg_pixel;
    endfunction

    int         m_fcnt;
    int         exp_addr [2];
    logic       pv [3];
    logic [7:0] pp [3];
    logic [7:0] hold;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fcnt <= 0;
            exp_addr[0] <= 0;
            exp_addr[1] <= 0;
            for (int k = 0; k < 3; k++) begin
                pv[k] <= 1'b0;
                pp[k] <= '0;
            end
            hold <= '0;
        end else begin
            exp_addr[0] <= m_hit(0, m_fcnt) ? m_addr(0) : 0;
            exp_addr[1] <= m_hit(1, m_fcnt) ? m_addr(1) : 0;
            pv[0] <= pix_valid;
            pp[0] <= m_pix(m_fcnt);
            pv[1] <= pv[0];
            pp[1] <= pp[0];
            pv[2] <= pv[1];
            pp[2] <= pp[1];
            if (pv[1]) hold <= pp[1];
            if (frame_start) m_fcnt <= (m_fcnt + 1) % (1 << (FLASH_BIT + 1));
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("model_rom_addr0", int'(rom_addr[17:0]), exp_addr[0]);
            chk("model_rom_addr1", int'(rom_addr[35:18]), exp_addr[1]);
            chk("model_valid", int'(pixel_out_valid), int'(pv[2]));
            chk("model_pixel", int'(pixel_out), int'(hold));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(bit v, int x, int y, logic [7:0] b);
        pix_valid = v;
        pixel_x   = 10'(x);
        pixel_y   = 10'(y);
        bg_pixel  = b;
    endtask

    task automatic set_layer(int i, int x, int y, int f, bit e, bit fl, bit fs);
        sx[i] = 10'(x);
        sy[i] = 10'(y);
        sf[i] = 4'(f);
        en[i] = e;
        flip[i] = fl;
        flash[i] = fs;
    endtask

    initial begin
        set_layer(0, 0, 0, 0, 0, 0, 0);
        set_layer(1, 0, 0, 0, 0, 0, 0);
        ovr0[0]     = 8'h55;
        ovr0[112]   = 8'h66;
        ovr0[35594] = 8'h77;
        #1 rst = 1'b1;
        step();
        chk("reset_valid", int'(pixel_out_valid), 0);
        chk("reset_pixel", int'(pixel_out), 0);
        chk("reset_addr", int'(rom_addr), 0);
        step();
        rst = 1'b0;
        checking = 1;
        step();

        // basic addressing, no flip
        set_layer(0, 100, 200, 0, 1, 0, 0);
        drive(1, 100, 200, 8'h10); step();
        chk("addr_left_edge", int'(rom_addr[17:0]), 0);
        drive(1, 212, 200, 8'h11); step();
        chk("addr_right_edge", int'(rom_addr[17:0]), 112);
        drive(0, 0, 0, 8'h00); step();
        chk("pix_left_edge", int'(pixel_out), 8'h55);
        chk("valid_latency", int'(pixel_out_valid), 1);
        step();
        chk("pix_right_edge", int'(pixel_out), 8'h66);
        step(); step();

        // flip + frame 2, then just outside the sprite
        set_layer(0, 100, 200, 2, 1, 1, 0);
        drive(1, 100, 200, 8'h12); step();
        chk("addr_flip_frame2", int'(rom_addr[17:0]), 35594);
        drive(1, 213, 200, 8'h13); step();
        chk("addr_outside", int'(rom_addr[17:0]), 0);
        drive(0, 0, 0, 8'h00); step();
        chk("pix_flip_frame2", int'(pixel_out), 8'h77);
        step();
        chk("pix_outside_bg", int'(pixel_out), 8'h13);
        step(); step();

        // priority: transparent layer 0 reveals layer 1, opaque layer 0 wins
        set_layer(0, 300, 100, 0, 1, 0, 0);
        set_layer(1, 300, 100, 0, 1, 0, 0);
        ovr0[1135] = TKEY;
        ovr1[1135] = 8'h1C;
        drive(1, 305, 110, 8'h44); step();
        chk("addr_overlap_l1", int'(rom_addr[35:18]), 1135);
        drive(0, 0, 0, 8'h00); step(); step();
        chk("pix_transparent_l0", int'(pixel_out), 8'h1C);
        step();
        ovr0[1135] = 8'h03;
        drive(1, 305, 110, 8'h44); step();
        drive(0, 0, 0, 8'h00); step(); step();
        chk("pix_opaque_l0", int'(pixel_out), 8'h03);
        step();

        // right-edge wrap and out-of-range frame
        set_layer(1, 0, 0, 0, 0, 0, 0);
        set_layer(0, 1000, 0, 0, 1, 0, 0);
        drive(1, 5, 5, 8'h50); step();
        chk("addr_no_wrap", int'(rom_addr[17:0]), 0);
        drive(1, 1010, 5, 8'h51); step();
        chk("addr_near_1023", int'(rom_addr[17:0]), 575);
        sf[0] = 4'd11;
        drive(1, 1010, 5, 8'h52); step();
        chk("addr_bad_frame", int'(rom_addr[17:0]), 0);
        drive(0, 0, 0, 8'h00); step(); step();
        chk("pix_bad_frame_bg", int'(pixel_out), 8'h52);
        step();

        // flash gating
        set_layer(0, 100, 200, 0, 1, 0, 1);
        drive(1, 101, 200, 8'h20); step();
        chk("flash_visible_start", int'(rom_addr[17:0]), 1);
        drive(0, 101, 200, 8'h00);
        for (int n = 0; n < 3; n++) begin
            frame_start = 1'b1; step();
            frame_start = 1'b0;
        end
        frame_start = 1'b1;
        drive(1, 101, 200, 8'h21); step();
        chk("flash_coincident_old", int'(rom_addr[17:0]), 1);
        frame_start = 1'b0;
        drive(1, 101, 200, 8'h22); step();
        chk("flash_hidden", int'(rom_addr[17:0]), 0);
        drive(0, 101, 200, 8'h00); step(); step();
        chk("flash_hidden_bg", int'(pixel_out), 8'h22);
        for (int n = 0; n < 4; n++) begin
            frame_start = 1'b1; step();
            frame_start = 1'b0;
        end
        drive(1, 101, 200, 8'h23); step();
        chk("flash_visible_again", int'(rom_addr[17:0]), 1);
        drive(0, 0, 0, 8'h00); step(); step(); step();

        // reset with pixels in flight
        flash[0] = 1'b0;
        drive(1, 100, 200, 8'h30); step();
        drive(1, 101, 200, 8'h31); step();
        drive(1, 102, 200, 8'h32); step();
        drive(0, 0, 0, 8'h00);
        rst = 1'b1;
        #1;
        chk("midrst_valid", int'(pixel_out_valid), 0);
        chk("midrst_pixel", int'(pixel_out), 0);
        step();
        rst = 1'b0;
        step(); step();
        chk("postrst_idle_valid", int'(pixel_out_valid), 0);
        drive(1, 100, 200, 8'h40); step();
        drive(0, 0, 0, 8'h00); step();
        chk("postrst_not_yet", int'(pixel_out_valid), 0);
        step();
        chk("postrst_first_valid", int'(pixel_out_valid), 1);
        chk("postrst_first_pixel", int'(pixel_out), 8'h55);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
